lsu_bus: RTL and testbench
==========================

# lsu_bus

Load/store bus bridge directly downstream of the execute unit's memory port. It accepts one load or store request per instruction, runs it on a single-outstanding req/gnt/rvalid bus, and returns a one-cycle `mem_ack_o` plus registered read data. The execute unit holds its load/store stall until that ack.

## Interface
Parameters:
- `TIMEOUT_CYC`, default 255: bus wait limit in cycles. Used only with `LSU_TIMEOUT_EN`. Legal range 1..65535.

Ports:
- `clk`  in  1  core clock; single clock domain.
- `rst`  in  1  synchronous, active-high reset.
- `mem_sel_i`  in  1  request valid from execute; held stable until ack.
- `mem_wen_i`  in  1  1 = store, 0 = load.
- `mem_addr_i`  in  32  byte address.
- `mem_wdata_i`  in  32  lane-aligned store data.
- `mem_wmask_i`  in  4  byte-lane store mask.
- `mem_rdata_o`  out  32  registered load word (full 32-bit word, unextended).
- `mem_ack_o`  out  1  one-cycle completion pulse.
- `err_o`  out  1  timeout flag; valid with `mem_ack_o`.
- `busy_o`  out  1  high whenever state is not IDLE.
- `bus_req_o`  out  1  bus request.
- `bus_we_o`  out  1  bus write.
- `bus_addr_o`  out  32  word address; `{addr[31:2],2'b00}`.
- `bus_wdata_o`  out  32  write data.
- `bus_be_o`  out  4  byte enables.
- `bus_gnt_i`  in  1  request accepted.
- `bus_rvalid_i`  in  1  response valid, for both reads and writes.
- `bus_rdata_i`  in  32  read data; valid with `bus_rvalid_i`.

## Operation
FSM states: IDLE, REQ, RESP, ACK.
- **IDLE**
  - If `mem_sel_i`=1: latch `bus_we_o`, `bus_addr_o`, `bus_wdata_o` and `bus_be_o`, then go to REQ.
  - `bus_be_o` = `mem_wmask_i` for stores, 4'b1111 for loads.
  - `bus_wdata_o` = 0 for loads.
- **REQ**
  - `bus_req_o`=1; address, data and enable outputs held stable.
  - On `bus_gnt_i`=1: drop `bus_req_o` at that edge and go to RESP.
- **RESP**
  - Wait for `bus_rvalid_i`.
  - On rvalid: register `mem_rdata_o` = `bus_rdata_i` (loads only; stores leave `mem_rdata_o` unchanged), then go to ACK.
- **ACK**
  - `mem_ack_o`=1 for exactly this cycle.
  - `mem_sel_i` is ignored in this state, so the same instruction is never reissued while the execute unit retires it.
  - Unconditionally return to IDLE.
- **Stray responses:** `bus_rvalid_i` in IDLE, REQ or ACK is ignored.
- **Request changes:** `mem_sel_i` falling mid-transaction does not abort; the transaction completes and acks.
- **Latched operands:** request fields are captured in IDLE only; later changes on `mem_*_i` have no effect until the next IDLE acceptance.
- **Read data:** `mem_rdata_o` holds its value until the next load completes.
- **Misalignment:** not checked. Sub-word lane selection is done by the execute unit.
- **Reset**
  - Every output is 0 at reset: `mem_rdata_o`, `mem_ack_o`, `err_o`, `busy_o`, `bus_req_o`, `bus_we_o`, `bus_addr_o`, `bus_wdata_o`, `bus_be_o`.
  - Reset mid-transaction forces IDLE and zeroes all outputs at that edge, dropping `bus_req_o` without waiting for gnt.

## Timing
- All outputs are registered except `busy_o`, which is decoded from the state register.
- **Minimum latency, sel to ack = 3 cycles**:
  - Cycle 0: sel sampled in IDLE.
  - Cycle 1: REQ with `bus_req_o`=1; gnt in the same cycle.
  - Cycle 2: RESP; rvalid in the same cycle.
  - Cycle 3: ACK.
- Each gnt wait or rvalid wait cycle adds one cycle.
- `bus_gnt_i` may be asserted combinationally in the first REQ cycle.
- `bus_rvalid_i` is never expected in the gnt cycle; the bus returns it at least one cycle after gnt.
- **Back-to-back:** with `mem_sel_i` held high across ACK, the next request is accepted in the IDLE cycle after ACK. Peak throughput is one transaction per 4 cycles.

## Configuration
- **`LSU_TIMEOUT_EN` defined**
  - A 16-bit counter clears on entry to REQ and increments every cycle in REQ or RESP.
  - When the count equals `TIMEOUT_CYC`, the transaction ends:
    - `bus_req_o` drops;
    - state goes to ACK with `err_o`=1;
    - `mem_rdata_o` = 32'h0000_0000 for a timed-out load.
  - `err_o` is 0 on every normal ack.
  - A late rvalid after a timeout is ignored.
- **`LSU_TIMEOUT_EN` undefined**
  - No counter is built; the block waits indefinitely.
  - `err_o` is tied to 0.

## Test plan
- **Store word:** addr 0x0000_1006, wdata 0xA5A5_1234, mask 4'b1111, gnt and rvalid immediate.
  - Expect `bus_addr_o`=0x0000_1004, `bus_be_o`=4'b1111 and `bus_we_o`=1 at cycle 1.
  - Expect `mem_ack_o` exactly at cycle 3 with `err_o`=0.
- **Load with delays:** load addr 0x0000_2000, gnt delayed 2 cycles, rvalid 3 cycles after gnt with data 0xDEAD_BEEF.
  - Expect `bus_be_o`=4'b1111, `bus_wdata_o`=0 and `bus_req_o` high for exactly 3 cycles.
  - Expect ack at cycle 7, then `mem_rdata_o`=0xDEAD_BEEF held until the next load completes.
- **Back-to-back:** hold `mem_sel_i` high through two store requests, changing the address after the first ack.
  - Expect two distinct bus transactions, ack at cycles 3 and 7, and no reissue during ACK.
- **Reset mid-transaction:** assert `rst` in RESP.
  - Expect all outputs 0 at the next edge.
  - Expect a subsequent rvalid to be ignored and a new request to complete normally.
- **Timeout:** with `LSU_TIMEOUT_EN` and `TIMEOUT_CYC`=8, never assert gnt.
  - Expect `bus_req_o` to drop and ack with `err_o`=1 and `mem_rdata_o`=0.
  - Without the macro, expect `bus_req_o` held and no ack after 100 cycles.
- **Byte store lanes:** `mem_wmask_i`=4'b0100, addr 0x0000_3002.
  - Expect `bus_be_o`=4'b0100 and `bus_addr_o`=0x0000_3000.

Source files
------------

// File: rtl/lsu_bus.sv
// lsu_bus: load/store bridge from the execute memory port to a single-outstanding req/gnt/rvalid bus.
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   mem_sel_i .. mem_wmask_i  request from execute (held until mem_ack_o)
//   mem_rdata_o               registered load word, held until the next load completes
//   mem_ack_o, err_o          one-cycle completion pulse and timeout flag (valid with ack)
//   busy_o                    high whenever the FSM is not idle
//   bus_req_o .. bus_be_o     bus request side, registered and stable while requesting
//   bus_gnt_i, bus_rvalid_i,
//   bus_rdata_i               bus handshake and response
// Optional feature: define LSU_TIMEOUT_EN to end a transaction with err_o after TIMEOUT_CYC cycles.
module lsu_bus #(
    parameter int TIMEOUT_CYC = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_sel_i,
    input  logic        mem_wen_i,
    input  logic [31:0] mem_addr_i,
    input  logic [31:0] mem_wdata_i,
    input  logic [3:0]  mem_wmask_i,
    output logic [31:0] mem_rdata_o,
    output logic        mem_ack_o,
    output logic        err_o,
    output logic        busy_o,
    output logic        bus_req_o,
    output logic        bus_we_o,
    output logic [31:0] bus_addr_o,
    output logic [31:0] bus_wdata_o,
    output logic [3:0]  bus_be_o,
    input  logic        bus_gnt_i,
    input  logic        bus_rvalid_i,
    input  logic [31:0] bus_rdata_i
);
    typedef enum logic [1:0] {IDLE, REQ, RESP, ACK} state_t;
    state_t state, state_nxt;
    logic active, tmo;
    assign active = (state == REQ) || (state == RESP);
    assign busy_o = state != IDLE;
`ifdef LSU_TIMEOUT_EN
    logic [15:0] cnt;
    // Zero in the first REQ cycle, counts every cycle spent on the bus.
    always_ff @(posedge clk) begin
        if (rst) cnt <= '0;
        else cnt <= active ? cnt + 16'd1 : 16'd0;
    end
    assign tmo = active && (cnt == 16'(TIMEOUT_CYC));
`else
    logic [15:0] unused_lim;
    assign unused_lim = 16'(TIMEOUT_CYC);
    assign tmo = 1'b0;
`endif
    // A timeout takes priority over a gnt or rvalid arriving in the same cycle.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = mem_sel_i ? REQ : IDLE;
            REQ:     state_nxt = tmo ? ACK : (bus_gnt_i ? RESP : REQ);
            RESP:    state_nxt = (tmo || bus_rvalid_i) ? ACK : RESP;
            default: state_nxt = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            mem_rdata_o <= '0;
            mem_ack_o   <= 1'b0;
            err_o       <= 1'b0;
            bus_req_o   <= 1'b0;
            bus_we_o    <= 1'b0;
            bus_addr_o  <= '0;
            bus_wdata_o <= '0;
            bus_be_o    <= '0;
        end else begin
            state     <= state_nxt;
            bus_req_o <= state_nxt == REQ;
            mem_ack_o <= state_nxt == ACK;
            err_o     <= tmo;
            if (state == IDLE && mem_sel_i) begin
                bus_we_o    <= mem_wen_i;
                bus_addr_o  <= mem_addr_i & 32'hFFFF_FFFC;
                bus_wdata_o <= mem_wen_i ? mem_wdata_i : 32'h0;
                bus_be_o    <= mem_wen_i ? mem_wmask_i : 4'hF;
            end
            // Only loads touch the read register; a timed-out load returns zero.
            if (!bus_we_o && (tmo || (state == RESP && bus_rvalid_i)))
                mem_rdata_o <= tmo ? 32'h0 : bus_rdata_i;
        end
    end
endmodule

// File: tb/tb_lsu_bus.sv
// tb_lsu_bus: randomized self-checking bench for lsu_bus against a transaction-level model.
module tb_lsu_bus;
    logic        clk = 1'b0;
    logic        rst;
    logic        mem_sel, mem_wen;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_wmask;
    logic [31:0] mem_rdata_o;
    logic        mem_ack_o, err_o, busy_o;
    logic        bus_req_o, bus_we_o;
    logic [31:0] bus_addr_o, bus_wdata_o;
    logic [3:0]  bus_be_o;
    logic        bus_gnt, bus_rvalid;
    logic [31:0] bus_rdata;
    int          tests = 0;
    int          fails = 0;
    logic [31:0] exp_rdata;

    lsu_bus #(.TIMEOUT_CYC(8)) dut (
        .clk(clk), .rst(rst),
        .mem_sel_i(mem_sel), .mem_wen_i(mem_wen), .mem_addr_i(mem_addr),
        .mem_wdata_i(mem_wdata), .mem_wmask_i(mem_wmask),
        .mem_rdata_o(mem_rdata_o), .mem_ack_o(mem_ack_o), .err_o(err_o), .busy_o(busy_o),
        .bus_req_o(bus_req_o), .bus_we_o(bus_we_o), .bus_addr_o(bus_addr_o),
        .bus_wdata_o(bus_wdata_o), .bus_be_o(bus_be_o),
        .bus_gnt_i(bus_gnt), .bus_rvalid_i(bus_rvalid), .bus_rdata_i(bus_rdata)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d fails=%0d", tests, fails);
        $fatal(1);
    end

    // One transaction. Called at a negedge in the cycle where sel is first presented
    // (or, if chained, at the negedge of the previous ACK cycle). Inputs are driven
    // and outputs sampled at negedges. Expected: ack at cycle 2+gd+rv, req for gd+1 cycles.
    task automatic run_txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [3:0] mask, input int gd, input int rv, input bit chained,
                           input bit keep, input bit scramble, output int ack_at);
        logic [31:0] ea, ew, rd;
        logic [3:0]  eb;
        int reqc, gcyc;
        ea = addr & 32'hFFFF_FFFC;
        eb = we ? mask : 4'hF;
        ew = we ? wdata : 32'h0;
        rd = $urandom;
        reqc = 0;
        gcyc = -1;
        ack_at = -1;
        if (chained) begin
            @(negedge clk);
            bus_gnt = 1'b0;
            bus_rvalid = 1'b0;
            tests++;
            if ({mem_ack_o, busy_o, bus_req_o} !== 3'b000) begin
                fails++;
                $display("FAIL idle_after_ack: ack/busy/req=%b expected 000", {mem_ack_o, busy_o, bus_req_o});
            end
        end
        mem_sel = 1'b1; mem_wen = we; mem_addr = addr; mem_wdata = wdata; mem_wmask = mask;
        for (int c = 1; c <= 60 && ack_at < 0; c++) begin
            @(negedge clk);
            bus_gnt = 1'b0;
            bus_rvalid = 1'b0;
            bus_rdata = $urandom;
            if (scramble && c == 1) begin
                mem_sel = 1'($urandom_range(0, 1));
                mem_wen = 1'($urandom_range(0, 1));
                mem_addr = $urandom;
                mem_wdata = $urandom;
                mem_wmask = 4'($urandom);
            end
            if (bus_req_o) begin
                reqc++;
                tests++;
                if ({bus_we_o, bus_addr_o, bus_wdata_o, bus_be_o} !== {we, ea, ew, eb}) begin
                    fails++;
                    $display("FAIL bus_fields: we/addr/wdata/be=%b/%h/%h/%b expected %b/%h/%h/%b",
                             bus_we_o, bus_addr_o, bus_wdata_o, bus_be_o, we, ea, ew, eb);
                end
                if (reqc == gd + 1) begin
                    bus_gnt = 1'b1;
                    gcyc = c;
                end else if (scramble) bus_rvalid = 1'($urandom_range(0, 1));
            end
            if (gcyc > 0 && c == gcyc + rv) begin
                bus_rvalid = 1'b1;
                bus_rdata = rd;
            end
            if (mem_ack_o) begin
                ack_at = c;
                if (!we) exp_rdata = rd;
                if (scramble) bus_rvalid = 1'b1;
            end
        end
        if (ack_at < 0) begin
            tests++;
            fails++;
            $display("FAIL ack_missing: no ack within 60 cycles, expected at cycle %0d", 2 + gd + rv);
            mem_sel = 1'b0;
            return;
        end
        tests++;
        if (ack_at != 2 + gd + rv) begin
            fails++;
            $display("FAIL ack_cycle: ack at cycle %0d expected %0d", ack_at, 2 + gd + rv);
        end
        tests++;
        if (reqc != gd + 1) begin
            fails++;
            $display("FAIL req_cycles: req high %0d cycles expected %0d", reqc, gd + 1);
        end
        tests++;
        if ({err_o, bus_req_o, busy_o} !== 3'b001) begin
            fails++;
            $display("FAIL ack_flags: err/req/busy=%b expected 001", {err_o, bus_req_o, busy_o});
        end
        tests++;
        if (mem_rdata_o !== exp_rdata) begin
            fails++;
            $display("FAIL rdata_at_ack: got %h expected %h", mem_rdata_o, exp_rdata);
        end
        if (!keep) begin
            mem_sel = 1'b0;
            @(negedge clk);
            bus_gnt = 1'b0;
            bus_rvalid = 1'b0;
            tests++;
            if ({mem_ack_o, busy_o} !== 2'b00 || mem_rdata_o !== exp_rdata) begin
                fails++;
                $display("FAIL after_ack: ack/busy=%b rdata=%h expected 00 %h",
                         {mem_ack_o, busy_o}, mem_rdata_o, exp_rdata);
            end
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; mem_sel = 1'b0; mem_wen = 1'b0; mem_addr = '0; mem_wdata = '0; mem_wmask = '0;
        bus_gnt = 1'b0; bus_rvalid = 1'b0; bus_rdata = '0;
        repeat (3) @(negedge clk);
        tests++;
        if ({mem_rdata_o, mem_ack_o, err_o, busy_o, bus_req_o, bus_we_o, bus_addr_o, bus_wdata_o, bus_be_o} !== '0) begin
            fails++;
            $display("FAIL reset_outputs: rdata=%h ack=%b err=%b busy=%b req=%b we=%b addr=%h wdata=%h be=%b expected all 0",
                     mem_rdata_o, mem_ack_o, err_o, busy_o, bus_req_o, bus_we_o, bus_addr_o, bus_wdata_o, bus_be_o);
        end
        rst = 1'b0;
        exp_rdata = '0;
        @(negedge clk);
        tests++;
        if ({mem_ack_o, busy_o, bus_req_o} !== 3'b000) begin
            fails++;
            $display("FAIL idle_after_reset: ack/busy/req=%b expected 000", {mem_ack_o, busy_o, bus_req_o});
        end
    endtask

    task automatic test_store_word;
        int a;
        run_txn(1'b1, 32'h0000_1006, 32'hA5A5_1234, 4'b1111, 0, 1, 1'b0, 1'b0, 1'b0, a);
    endtask

    task automatic test_load_delays;
        int a;
        run_txn(1'b0, 32'h0000_2000, 32'h1111_2222, 4'b0011, 2, 3, 1'b0, 1'b0, 1'b0, a);
        tests++;
        if (mem_rdata_o !== exp_rdata || a != 7) begin
            fails++;
            $display("FAIL load_delays: rdata=%h ack=%0d expected %h at 7", mem_rdata_o, a, exp_rdata);
        end
        // A store must leave the loaded word untouched.
        run_txn(1'b1, 32'h0000_2004, 32'h0BAD_F00D, 4'b1111, 1, 2, 1'b0, 1'b0, 1'b0, a);
    endtask

    task automatic test_back_to_back;
        int a1, a2;
        run_txn(1'b1, 32'h0000_0100, 32'h1234_5678, 4'b1111, 0, 1, 1'b0, 1'b1, 1'b0, a1);
        run_txn(1'b1, 32'h0000_0204, 32'h8765_4321, 4'b0011, 0, 1, 1'b1, 1'b0, 1'b0, a2);
        tests++;
        if (a1 != 3 || a1 + 1 + a2 != 7) begin
            fails++;
            $display("FAIL back_to_back: acks at %0d and %0d expected 3 and 7", a1, a1 + 1 + a2);
        end
    endtask

    task automatic test_reset_mid;
        int a;
        mem_sel = 1'b1; mem_wen = 1'b0; mem_addr = 32'h0000_4000;
        @(negedge clk);
        bus_gnt = 1'b1;
        @(negedge clk);
        bus_gnt = 1'b0;
        tests++;
        if ({busy_o, bus_req_o, mem_ack_o} !== 3'b100) begin
            fails++;
            $display("FAIL resp_state: busy/req/ack=%b expected 100", {busy_o, bus_req_o, mem_ack_o});
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        mem_sel = 1'b0;
        exp_rdata = '0;
        tests++;
        if ({mem_rdata_o, mem_ack_o, err_o, busy_o, bus_req_o, bus_we_o, bus_addr_o, bus_wdata_o, bus_be_o} !== '0) begin
            fails++;
            $display("FAIL reset_mid: rdata=%h ack=%b err=%b busy=%b req=%b addr=%h be=%b expected all 0",
                     mem_rdata_o, mem_ack_o, err_o, busy_o, bus_req_o, bus_addr_o, bus_be_o);
        end
        bus_rvalid = 1'b1;
        bus_rdata = 32'hCAFE_F00D;
        @(negedge clk);
        bus_rvalid = 1'b0;
        tests++;
        if (mem_rdata_o !== 32'h0 || {mem_ack_o, busy_o} !== 2'b00) begin
            fails++;
            $display("FAIL stray_rvalid: rdata=%h ack/busy=%b expected 0 00", mem_rdata_o, {mem_ack_o, busy_o});
        end
        run_txn(1'b0, 32'h0000_4008, 32'h0, 4'h0, 1, 1, 1'b0, 1'b0, 1'b0, a);
    endtask

    task automatic test_timeout;
        int reqc, ackc;
        logic [31:0] ack_state;
        reqc = 0;
        ackc = 0;
        ack_state = '1;
        mem_sel = 1'b1; mem_wen = 1'b0; mem_addr = 32'h0000_5000;
        bus_gnt = 1'b0;
        for (int c = 1; c <= 100; c++) begin
            @(negedge clk);
            mem_sel = 1'b0;
            if (bus_req_o) reqc++;
            if (mem_ack_o) begin
                ackc++;
                ack_state = {29'h0, err_o, bus_req_o, 1'b0} | mem_rdata_o;
            end
        end
`ifdef LSU_TIMEOUT_EN
        exp_rdata = '0;
        tests++;
        if (ackc != 1 || ack_state !== 32'h4 || reqc < 8 || reqc > 10) begin
            fails++;
            $display("FAIL timeout: acks=%0d err|req|rdata=%h req_cycles=%0d expected 1 ack, 00000004, 8..10",
                     ackc, ack_state, reqc);
        end
        bus_rvalid = 1'b1;
        bus_rdata = 32'h7777_7777;
        @(negedge clk);
        bus_rvalid = 1'b0;
        tests++;
        if (mem_rdata_o !== 32'h0 || mem_ack_o !== 1'b0) begin
            fails++;
            $display("FAIL late_rvalid: rdata=%h ack=%b expected 0 0", mem_rdata_o, mem_ack_o);
        end
`else
        tests++;
        if (ackc != 0 || reqc != 100 || err_o !== 1'b0) begin
            fails++;
            $display("FAIL no_timeout: acks=%0d req_cycles=%0d err=%b expected 0 100 0", ackc, reqc, err_o);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        exp_rdata = '0;
        tests++;
        if ({bus_req_o, busy_o} !== 2'b00) begin
            fails++;
            $display("FAIL reset_drop_req: req/busy=%b expected 00", {bus_req_o, busy_o});
        end
`endif
    endtask

    task automatic test_byte_lanes;
        int a;
        run_txn(1'b1, 32'h0000_3002, 32'h00AB_0000, 4'b0100, 0, 1, 1'b0, 1'b0, 1'b0, a);
    endtask

    task automatic test_random;
        int a;
        for (int i = 0; i < 40; i++)
            run_txn(1'($urandom_range(0, 1)), $urandom, $urandom, 4'($urandom),
                    int'($urandom_range(0, 3)), int'($urandom_range(1, 3)), 1'b0, 1'b0, 1'b1, a);
    endtask

    initial begin
        test_reset;
        test_store_word;
        test_load_delays;
        test_back_to_back;
        test_reset_mid;
        test_timeout;
        test_byte_lanes;
        test_random;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
